// File: rtl/sdram_pkg.sv
// sdram_pkg: shared FSM states, owner encoding and default timing parameters
package sdram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  typedef enum logic [1:0] {NONE, P0, P1, REF} owner_t;
  localparam int REFRESH_INTERVAL_DEF = 810;
  localparam int FAIR_LIMIT_DEF = 4;
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: periodic refresh request with sticky overrun flag
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic enabled,
  input  logic clear,
  output logic pending,
  output logic overrun
);
  localparam int CW = REFRESH_INTERVAL > 1 ? $clog2(REFRESH_INTERVAL) : 1;
  logic [CW-1:0] cnt;
  logic expire;
  assign expire = enabled && cnt == CW'(REFRESH_INTERVAL - 1);
  // a new expiry beats a same-cycle clear, and expiring onto a pending refresh is an overrun
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (enabled) cnt <= expire ? '0 : cnt + 1'b1;
      pending <= expire | (pending & ~clear);
      overrun <= overrun | (expire & pending);
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port SDRAM request arbiter with refresh priority and port-1 fairness
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [22:0] p0_addr,
  input  logic [22:0] p1_addr,
  input  logic [15:0] p0_din,
  input  logic [15:0] p1_din,
  input  logic [1:0]  p0_wdm,
  input  logic [1:0]  p1_wdm,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic [15:0] p0_rdata,
  output logic [15:0] p1_rdata,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        sd_refresh,
  output logic [22:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_wdm,
  input  logic [15:0] sd_dout,
  input  logic        sd_data_ready,
  input  logic        sd_busy,
  input  logic        sd_enabled,
  output logic        refresh_overrun
);
  localparam int SW = $clog2(FAIR_LIMIT + 1);
  state_t state;
  owner_t owner, win;
  logic is_read, ref_pending, ref_clear, fair_p1, grant_we, rd_hit;
  logic [SW-1:0] streak;
  assign ref_clear = state == ISSUE && owner == REF;
  assign fair_p1 = p1_req && streak >= SW'(FAIR_LIMIT);
  assign win = !(state == IDLE && sd_enabled && !sd_busy) ? NONE :
               ref_pending ? REF : (p0_req && !fair_p1) ? P0 : p1_req ? P1 : NONE;
  assign grant_we = win == P1 ? p1_we : p0_we;
  assign rd_hit = sd_data_ready && is_read && state != IDLE;
  sdram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk(clk),
    .resetn(resetn),
    .enabled(sd_enabled),
    .clear(ref_clear),
    .pending(ref_pending),
    .overrun(refresh_overrun)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      owner <= NONE;
      is_read <= 1'b0;
      streak <= '0;
      sd_rd <= 1'b0;
      sd_wr <= 1'b0;
      sd_refresh <= 1'b0;
      sd_addr <= '0;
      sd_din <= '0;
      sd_wdm <= '0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      sd_rd <= 1'b0;
      sd_wr <= 1'b0;
      sd_refresh <= 1'b0;
      p0_rvalid <= rd_hit && owner == P0;
      p1_rvalid <= rd_hit && owner == P1;
      if (rd_hit && owner == P0) p0_rdata <= sd_dout;
      if (rd_hit && owner == P1) p1_rdata <= sd_dout;
      case (state)
        IDLE: if (win != NONE) begin
          state <= ISSUE;
          owner <= win;
          is_read <= win != REF && !grant_we;
          sd_rd <= win != REF && !grant_we;
          sd_wr <= win != REF && grant_we;
          sd_refresh <= win == REF;
          sd_addr <= win == P1 ? p1_addr : win == P0 ? p0_addr : '0;
          sd_din <= win == P1 ? p1_din : win == P0 ? p0_din : '0;
          sd_wdm <= win == P1 ? p1_wdm : win == P0 ? p0_wdm : '0;
          p0_ack <= win == P0;
          p1_ack <= win == P1;
          streak <= (win == P0 && p1_req) ? streak + 1'b1 : '0;
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: if (sd_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!sd_busy) begin
          state <= IDLE;
          owner <= NONE;
        end
      endcase
    end
endmodule
